apb_rr_master_ctrl: RTL and testbench
=====================================

Name: apb_rr_master_ctrl

Overview:
- Shares the single SoC peripheral APB bus among NB_REQ simple req/gnt requesters, such as the core data port and the debug unit.
- Arbitrates round-robin and decodes the peripheral address map into per-slave psel.
- Sequences the APB SETUP/ACCESS phases, times out hung slaves, and returns read data and an error flag to the winning requester.

Parameters:
- NB_REQ, 2, number of requesters (>=1)
- NB_SLAVE, 3, number of APB slaves; map is fixed below
- APB_ADDR_WIDTH, 32, paddr width
- APB_DATA_WIDTH, 32, pwdata/prdata width
- TIMEOUT_CYCLES, 16, max ACCESS-phase cycles before abort (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_i  in  NB_REQ  request per requester
- addr_i  in  NB_REQ*APB_ADDR_WIDTH  flattened address, requester k at [k*W+:W]
- we_i  in  NB_REQ  1=write
- wdata_i  in  NB_REQ*APB_DATA_WIDTH  flattened write data
- gnt_o  out  NB_REQ  one-hot request accepted
- rvalid_o  out  NB_REQ  one-hot response valid
- rdata_o  out  APB_DATA_WIDTH  read data, shared by all requesters
- err_o  out  1  response error, valid with rvalid_o
- paddr  out  APB_ADDR_WIDTH  APB address
- pwdata  out  APB_DATA_WIDTH  APB write data
- pwrite  out  1  APB direction
- psel  out  NB_SLAVE  one-hot slave select
- penable  out  1  APB enable
- prdata  in  NB_SLAVE*APB_DATA_WIDTH  flattened per-slave read data
- pready  in  NB_SLAVE  per-slave ready
- pslverr  in  NB_SLAVE  per-slave error

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- All outputs are registered. On reset: every output is 0, FSM=IDLE, rr_ptr=0, timeout counter=0.
- Address map (inclusive):
  - slave0 UART 0x2100_0000–0x2100_0FFF
  - slave1 TIMER 0x2100_1000–0x2100_1FFF
  - slave2 EVENT_UNIT 0x2100_2000–0x2100_2FFF
  - any other address is a decode miss.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_i is set, the winner is the first set bit at or after rr_ptr, wrapping modulo NB_REQ.
  - gnt_o[winner]=1 for exactly one cycle. Latch addr, we, wdata and the winner index.
  - rr_ptr <= (winner+1) mod NB_REQ.
  - On a hit, go to SETUP. On a decode miss, go to RESP with err=1 and rdata=0; no psel is driven.
- SETUP: psel[slave]=1, penable=0, paddr/pwrite/pwdata from the latched values. Next state is ACCESS.
- ACCESS:
  - psel[slave]=1, penable=1; address and data are held stable.
  - If pready[slave]=1: capture prdata[slave] (zeroed on writes) and pslverr[slave], then go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES, abort: drop psel/penable, go to RESP with err=1, rdata=0.
- RESP:
  - psel=0, penable=0.
  - rvalid_o[winner]=1 for exactly one cycle, together with rdata_o/err_o. Next state is IDLE.
- Timing and outputs:
  - Minimum latency is 4 cycles from gnt to IDLE re-entry. rvalid follows gnt by 3 cycles for a zero-wait slave (pready=1 at first ACCESS).
  - rdata_o/err_o hold their last value outside rvalid.
- Requester rules:
  - Each requester holds req_i and its payload until gnt.
  - A requester may drop req before gnt; it is then not served.
  - req is ignored outside IDLE, so only one transaction is outstanding.
- Simultaneous requests: exactly one grant per cycle. A requester asserting continuously is granted at most once every NB_REQ grants while others request.
- pready/pslverr from non-selected slaves are ignored. pslverr counts only in the pready cycle.
- Reset mid-transaction: all outputs clear asynchronously and no rvalid is produced for the aborted transfer.

Test Plan:
- Single write, req0 addr 0x2100_1004 wdata 0xDEAD_BEEF, pready tied 1 -> gnt0 at T; psel=3'b010,penable=0 at T+1; penable=1 at T+2; rvalid0,err=0 at T+3.
- Read, req1 addr 0x2100_2008, slave2 pready after 3 wait cycles, prdata=0x1234_5678 -> rvalid1 with rdata=0x1234_5678, err=0, 6 cycles after gnt.
- Both requesters held continuously -> grants alternate 0,1,0,1; after reset the first grant goes to requester 0.
- Decode miss, addr 0x2100_3000 -> psel stays 0, rvalid at gnt+1 with err=1, rdata=0.
- Slave0 never asserts pready, TIMEOUT_CYCLES=16 -> 16 ACCESS cycles, then psel drops and err=1. Separately, pslverr=1 with pready=1 -> err=1.
- rst pulsed during ACCESS -> psel/penable/gnt/rvalid go to 0 immediately; the next request after reset completes normally.

Source files
------------

// File: rtl/apb_rr_master_ctrl.sv
// APB master front-end: round-robin arbitration of NB_REQ req/gnt ports onto one
// peripheral APB bus, with fixed address decode and an ACCESS-phase timeout.
module apb_rr_master_ctrl #(
  parameter int NB_REQ         = 2,
  parameter int NB_SLAVE       = 3,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NB_REQ-1:0]                  req_i,
  input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   addr_i,
  input  logic [NB_REQ-1:0]                  we_i,
  input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   wdata_i,
  output logic [NB_REQ-1:0]                  gnt_o,
  output logic [NB_REQ-1:0]                  rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]          rdata_o,
  output logic                               err_o,
  output logic [APB_ADDR_WIDTH-1:0]          paddr,
  output logic [APB_DATA_WIDTH-1:0]          pwdata,
  output logic                               pwrite,
  output logic [NB_SLAVE-1:0]                psel,
  output logic                               penable,
  input  logic [NB_SLAVE*APB_DATA_WIDTH-1:0] prdata,
  input  logic [NB_SLAVE-1:0]                pready,
  input  logic [NB_SLAVE-1:0]                pslverr
);

  // state  | meaning
  // IDLE   | arbitrate; while gnt_o is high, dispatch the latched request
  // SETUP  | APB setup phase (psel, no penable)
  // ACCESS | APB access phase, wait for pready or timeout
  // RESP   | one-cycle rvalid_o pulse to the winner

  localparam int RW = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
  localparam int SW = (NB_SLAVE > 1) ? $clog2(NB_SLAVE) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [APB_ADDR_WIDTH-1:0] MAP_BASE = APB_ADDR_WIDTH'(32'h2100_0000);
  localparam logic [APB_ADDR_WIDTH-1:0] MAP_SIZE = APB_ADDR_WIDTH'(NB_SLAVE * 4096);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state_q, state_d;
  logic [RW-1:0]             rr_ptr, rr_d;
  logic [RW-1:0]             win_q, win_d;
  logic [SW-1:0]             slv_q, slv_d;
  logic                      hit_q, hit_d;
  logic [CW-1:0]             cnt_q, cnt_d;

  logic [NB_REQ-1:0]         gnt_d, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_d, pwdata_d;
  logic                      err_d, pwrite_d, penable_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_d;
  logic [NB_SLAVE-1:0]       psel_d;

  logic [RW-1:0]             win, idx;
  logic                      any_req;
  logic [APB_ADDR_WIDTH-1:0] win_addr, win_off;
  logic                      win_hit;
  logic [SW-1:0]             win_slv;

  // Scan downwards so the nearest requester at or after rr_ptr wins last.
  always_comb begin
    win     = rr_ptr;
    idx     = rr_ptr;
    any_req = 1'b0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      idx = RW'((int'(rr_ptr) + i) % NB_REQ);
      if (req_i[idx]) begin
        win     = idx;
        any_req = 1'b1;
      end
    end
  end

  assign win_addr = addr_i[win*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
  assign win_off  = win_addr - MAP_BASE;
  assign win_hit  = (win_off < MAP_SIZE);
  assign win_slv  = win_off[12 +: SW];

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_ptr;
    win_d     = win_q;
    slv_d     = slv_q;
    hit_d     = hit_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    rvalid_d  = '0;
    rdata_d   = rdata_o;
    err_d     = err_o;
    paddr_d   = paddr;
    pwdata_d  = pwdata;
    pwrite_d  = pwrite;
    psel_d    = '0;
    penable_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|gnt_o) begin
          if (hit_q) begin
            state_d       = SETUP;
            psel_d[slv_q] = 1'b1;
          end else begin
            state_d         = RESP;
            rvalid_d[win_q] = 1'b1;
            rdata_d         = '0;
            err_d           = 1'b1;
          end
        end else if (any_req) begin
          gnt_d[win] = 1'b1;
          win_d      = win;
          rr_d       = (win == RW'(NB_REQ - 1)) ? '0 : win + 1'b1;
          paddr_d    = win_addr;
          pwrite_d   = we_i[win];
          pwdata_d   = wdata_i[win*APB_DATA_WIDTH +: APB_DATA_WIDTH];
          hit_d      = win_hit;
          slv_d      = win_slv;
        end
      end
      SETUP: begin
        state_d       = ACCESS;
        psel_d[slv_q] = 1'b1;
        penable_d     = 1'b1;
        cnt_d         = '0;
      end
      ACCESS: begin
        if (pready[slv_q]) begin
          state_d         = RESP;
          rvalid_d[win_q] = 1'b1;
          rdata_d         = pwrite ? '0 : prdata[slv_q*APB_DATA_WIDTH +: APB_DATA_WIDTH];
          err_d           = pslverr[slv_q];
          cnt_d           = '0;
        end else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
          state_d         = RESP;
          rvalid_d[win_q] = 1'b1;
          rdata_d         = '0;
          err_d           = 1'b1;
          cnt_d           = '0;
        end else begin
          cnt_d         = cnt_q + 1'b1;
          psel_d[slv_q] = 1'b1;
          penable_d     = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is a flop fed from the next-state decode above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      win_q    <= '0;
      slv_q    <= '0;
      hit_q    <= 1'b0;
      cnt_q    <= '0;
      gnt_o    <= '0;
      rvalid_o <= '0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      pwrite   <= 1'b0;
      psel     <= '0;
      penable  <= 1'b0;
    end else begin
      rr_ptr   <= rr_d;
      win_q    <= win_d;
      slv_q    <= slv_d;
      hit_q    <= hit_d;
      cnt_q    <= cnt_d;
      gnt_o    <= gnt_d;
      rvalid_o <= rvalid_d;
      rdata_o  <= rdata_d;
      err_o    <= err_d;
      paddr    <= paddr_d;
      pwdata   <= pwdata_d;
      pwrite   <= pwrite_d;
      psel     <= psel_d;
      penable  <= penable_d;
    end
  end

endmodule

// File: tb/tb_apb_rr_master_ctrl.sv
// Randomized bench for apb_rr_master_ctrl against a transaction-timeline model
// of grants, APB phases and responses.
module tb_apb_rr_master_ctrl;
  localparam int NR = 2, NS = 3, AW = 32, DW = 32, TO = 16;

  logic clk = 1'b0, rst = 1'b1;
  logic [NR-1:0]    req_i = '0, we_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR*DW-1:0] wdata_i = '0;
  logic [NR-1:0]    gnt_o, rvalid_o;
  logic [DW-1:0]    rdata_o;
  logic             err_o;
  logic [AW-1:0]    paddr;
  logic [DW-1:0]    pwdata;
  logic             pwrite;
  logic [NS-1:0]    psel;
  logic             penable;
  logic [NS*DW-1:0] prdata = '0;
  logic [NS-1:0]    pready = '0, pslverr = '0;

  apb_rr_master_ctrl #(
    .NB_REQ(NR), .NB_SLAVE(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int slave_of(input logic [31:0] a);
    if (a >= 32'h2100_0000 && a <= 32'h2100_0FFF) return 0;
    if (a >= 32'h2100_1000 && a <= 32'h2100_1FFF) return 1;
    if (a >= 32'h2100_2000 && a <= 32'h2100_2FFF) return 2;
    return -1;
  endfunction

  // Directed payloads handed out first, then directed slave behaviours per grant.
  logic [31:0] tab_addr [6] = '{32'h2100_1004, 32'h2100_2008, 32'h2100_3000,
                                32'h2100_0000, 32'h2100_0FFC, 32'h2100_2FFF};
  bit          tab_we   [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] tab_wd   [6] = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0};
  int          beh_wait [6] = '{0, 3, 0, -1, 0, 1};
  bit          beh_perr [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] beh_rd   [6] = '{32'h0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'hA5A5_0F0F};

  bit          rq [NR];
  bit          rw [NR];
  logic [31:0] ra [NR];
  logic [31:0] rd [NR];
  int ti = 0, gi = 0;

  task automatic new_payload(input int k);
    rq[k] = 1'b1;
    if (ti < 6) begin
      ra[k] = tab_addr[ti]; rw[k] = tab_we[ti]; rd[k] = tab_wd[ti]; ti++;
    end else begin
      case ($urandom_range(0, 5))
        0, 1, 2, 3: ra[k] = 32'h2100_0000 + ($urandom_range(0, 2) << 12) + ($urandom_range(0, 1023) << 2);
        4:          ra[k] = ($urandom_range(0, 1) == 1) ? 32'h2100_3000 : 32'h20FF_FFFC;
        default:    ra[k] = $urandom;
      endcase
      rw[k] = ($urandom_range(0, 1) == 1);
      rd[k] = $urandom;
    end
  endtask

  // Model of the transaction in flight; t counts cycles from its grant.
  bit          busy = 1'b0, free, thit, twe, tperr, rst_done = 1'b0, in_rst = 1'b0;
  int          t, tw, tslv, twait, tend, ptr = 0, grants = 0;
  logic [31:0] taddr, twd, tprd;
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_err = 1'b0;
  logic [NR-1:0] eg, ev;
  logic [NS-1:0] ep;
  logic          ee;

  initial begin
    for (int k = 0; k < NR; k++) begin rq[k] = 1'b0; rw[k] = 1'b0; ra[k] = '0; rd[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 64'(gnt_o), 64'(0));
    chk("reset_rvalid", 64'(rvalid_o), 64'(0));
    chk("reset_psel", 64'(psel), 64'(0));
    chk("reset_penable", 64'(penable), 64'(0));
    chk("reset_rdata", 64'(rdata_o), 64'(0));
    chk("reset_paddr", 64'(paddr), 64'(0));
    rst = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      #1;
      free = !busy;
      if (busy) t++;
      eg = '0; ep = '0; ee = 1'b0; ev = '0;
      if (busy) begin
        if (t == 0) eg[tw] = 1'b1;
        if (thit && t >= 1 && t < tend) ep[tslv] = 1'b1;
        if (thit && t >= 2 && t < tend) ee = 1'b1;
        if (t == tend) begin
          ev[tw]    = 1'b1;
          exp_rdata = (!thit || twait < 0 || twe) ? '0 : tprd;
          exp_err   = !thit || twait < 0 || tperr;
        end
      end
      chk("gnt", 64'(gnt_o), 64'(eg));
      chk("psel", 64'(psel), 64'(ep));
      chk("penable", 64'(penable), 64'(ee));
      chk("rvalid", 64'(rvalid_o), 64'(ev));
      chk("rdata", 64'(rdata_o), 64'(exp_rdata));
      chk("err", 64'(err_o), 64'(exp_err));
      if (busy && thit && t >= 1 && t < tend) begin
        chk("paddr", 64'(paddr), 64'(taddr));
        chk("pwrite", 64'(pwrite), 64'(twe));
        chk("pwdata", 64'(pwdata), 64'(twd));
      end

      if (in_rst) begin
        rst = 1'b0;
        in_rst = 1'b0;
      end

      // Slaves: noise everywhere except the selected slave during ACCESS.
      prdata  = {$urandom, $urandom, $urandom};
      pready  = NS'($urandom);
      pslverr = NS'($urandom);
      if (busy && thit && t >= 2 && t < tend) begin
        pready[tslv] = (twait >= 0 && t - 2 == twait);
        if (pready[tslv]) pslverr[tslv] = tperr;
        prdata[tslv*DW +: DW] = tprd;
      end

      // Requesters: continuous in the opening phase, random afterwards.
      for (int k = 0; k < NR; k++) begin
        if (eg[k]) begin
          if (cyc < 80 || $urandom_range(0, 1) == 1) new_payload(k);
          else rq[k] = 1'b0;
        end else if (!rq[k]) begin
          if (cyc < 80 || $urandom_range(0, 2) == 0) new_payload(k);
        end else if (cyc >= 80 && $urandom_range(0, 19) == 0) begin
          rq[k] = 1'b0;
        end
      end
      for (int k = 0; k < NR; k++) begin
        req_i[k] = rq[k];
        we_i[k]  = rw[k];
        addr_i[k*AW +: AW]  = ra[k];
        wdata_i[k*DW +: DW] = rd[k];
      end

      if (busy && t == tend) busy = 1'b0;

      if (free && (|req_i)) begin
        tw = ptr;
        while (!rq[tw]) tw = (tw + 1) % NR;
        ptr   = (tw + 1) % NR;
        taddr = ra[tw]; twe = rw[tw]; twd = rd[tw];
        tslv  = slave_of(taddr);
        thit  = (tslv >= 0);
        if (gi < 6) begin
          twait = beh_wait[gi]; tperr = beh_perr[gi]; tprd = beh_rd[gi];
        end else begin
          twait = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
          tperr = ($urandom_range(0, 3) == 0);
          tprd  = $urandom;
        end
        gi++;
        if (!thit) tslv = 0;
        tend   = !thit ? 1 : (twait < 0 ? 2 + TO : 3 + twait);
        busy   = 1'b1;
        t      = -1;
        grants++;
      end

      // Asynchronous reset in the middle of an ACCESS phase.
      if (!rst_done && cyc > 1500 && busy && thit && t == 3 && tend > 4) begin
        #3 rst = 1'b1;
        #1;
        chk("midrst_psel", 64'(psel), 64'(0));
        chk("midrst_penable", 64'(penable), 64'(0));
        chk("midrst_gnt", 64'(gnt_o), 64'(0));
        chk("midrst_rvalid", 64'(rvalid_o), 64'(0));
        chk("midrst_err", 64'(err_o), 64'(0));
        busy = 1'b0; ptr = 0; exp_rdata = '0; exp_err = 1'b0;
        for (int k = 0; k < NR; k++) rq[k] = 1'b0;
        req_i = '0;
        rst_done = 1'b1;
        in_rst   = 1'b1;
      end
    end

    chk("midrst_happened", 64'(rst_done), 64'(1));
    chk("enough_grants", 64'(grants >= 100), 64'(1));
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
